prf_wb_arbiter: RTL



---
 rtl/prf_wb_arbiter_pkg.sv | 45 ++++
 rtl/prf_wb_arbiter_rr_picker.sv | 47 ++++
 rtl/prf_wb_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/prf_wb_arbiter_pkg.sv
// Shared types for the PRF writeback arbiter.
// Optional feature macro: WB_ARB_RR_EN (round-robin grant; fixed priority when undefined).
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif
`ifndef XLEN
`define XLEN 64
`endif

package prf_wb_arbiter_pkg;

    localparam int WB_TAG_W  = $clog2(`PHYS_REG_SZ);
    localparam int WB_DATA_W = `XLEN;
    localparam int WB_MAX_REQ = 8;

    // One completion request from a functional unit
    typedef struct packed {
        logic                 valid;
        logic [WB_TAG_W-1:0]  tag;
        logic [WB_DATA_W-1:0] data;
    } WB_REQ_PACKET;

    // Registered PRF write port
    typedef struct packed {
        logic                 write_en;
        logic [WB_TAG_W-1:0]  write_tag;
        logic [WB_DATA_W-1:0] write_data;
    } IC_PRF_PACKET;

    // Registered completion broadcast
    typedef struct packed {
        logic                valid;
        logic [WB_TAG_W-1:0] tag;
    } CDB_PACKET;

    // Number of set bits in a request vector (zero-extended to the max width)
    function automatic int unsigned wb_popcount(input logic [WB_MAX_REQ-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < WB_MAX_REQ; i++)
            n += {31'b0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/prf_wb_arbiter_rr_picker.sv
// Rotating one-hot picker: rotate the request vector so ptr is at bit 0,
// take the lowest set bit, then rotate the grant back. Also returns the
// winner's index so callers can mux its payload.
module prf_wb_arbiter_rr_picker #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          grant_any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] gdbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   grot;
    logic [PW-1:0]  enc;
    logic [PW:0]    sum;

    // Rotate, priority-encode lowest bit, unrotate grant and index
    always_comb begin
        dbl       = {req, req} >> ptr;
        rot       = dbl[N-1:0];
        grot      = '0;
        enc       = '0;
        grant_any = 1'b0;
        // Walk downward so the lowest set bit is the last one written
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grot      = '0;
                grot[k]   = 1'b1;
                enc       = PW'(k);
                grant_any = 1'b1;
            end
        end
        gdbl  = {grot, grot} << ptr;
        grant = gdbl[2*N-1:N];
        sum   = {1'b0, enc} + {1'b0, ptr};
        if (sum >= (PW+1)'(N))
            grant_idx = PW'(sum - (PW+1)'(N));
        else
            grant_idx = sum[PW-1:0];
    end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Writeback arbiter: shares the single PRF write port among NUM_REQ
// functional units. One grant per cycle, result registered onto the PRF
// write port and CDB the following cycle. Tag 0 broadcasts but never writes.
// Optional feature macro: WB_ARB_RR_EN -- round-robin start pointer; when
// undefined the pointer is a constant 0 (lowest index wins).
module prf_wb_arbiter
    import prf_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = WB_TAG_W,
    parameter int DATA_W  = WB_DATA_W
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            squash,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            prf_write_en,
    output logic [TAG_W-1:0]                prf_write_tag,
    output logic [DATA_W-1:0]               prf_write_data,
    output logic                            cdb_valid,
    output logic [TAG_W-1:0]                cdb_tag,
    output logic [31:0]                     conflict_cnt
);

    // Payload structs are sized from the package; TAG_W/DATA_W must match it.
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    WB_REQ_PACKET       reqs [NUM_REQ];
    WB_REQ_PACKET       win;
    IC_PRF_PACKET       prf_q;
    CDB_PACKET          cdb_q;

    logic [NUM_REQ-1:0] vld_vec;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               grant_fire;
    logic [PTR_W-1:0]   rr_ptr;
    logic               conflict;
    logic [WB_MAX_REQ-1:0] vld_ext;

    // Pack flat ports into request structs
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign reqs[g].valid = req_valid[g];
        assign reqs[g].tag   = req_tag[g];
        assign reqs[g].data  = req_data[g];
        assign vld_vec[g]    = reqs[g].valid;
    end

    prf_wb_arbiter_rr_picker #(.N(NUM_REQ)) u_picker (
        .req       (vld_vec),
        .ptr       (rr_ptr),
        .grant     (gnt_oh),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    // Squash and reset both block the grant so nothing is consumed then lost
    assign grant_fire = gnt_any & ~squash & ~reset;
    assign req_ready  = grant_fire ? gnt_oh : '0;
    assign win        = reqs[gnt_idx];

`ifdef WB_ARB_RR_EN
    // Advance pointer past the winner; hold when nothing was granted
    always_ff @(posedge clock) begin
        if (reset)
            rr_ptr <= '0;
        else if (grant_fire)
            rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
`else
    assign rr_ptr = '0;
`endif

    // Register the winner onto the PRF port and CDB; tag/data hold when idle
    always_ff @(posedge clock) begin
        if (reset) begin
            prf_q <= '0;
            cdb_q <= '0;
        end else if (grant_fire) begin
            prf_q.write_en   <= (win.tag != '0);
            prf_q.write_tag  <= win.tag;
            prf_q.write_data <= win.data;
            cdb_q.valid      <= 1'b1;
            cdb_q.tag        <= win.tag;
        end else begin
            prf_q.write_en <= 1'b0;
            cdb_q.valid    <= 1'b0;
        end
    end

    // A conflict is any valid requester left waiting this cycle
    always_comb begin
        vld_ext = '0;
        vld_ext[NUM_REQ-1:0] = req_valid;
        conflict = wb_popcount(vld_ext) > (grant_fire ? 32'd1 : 32'd0);
    end

    // Saturating conflict counter
    always_ff @(posedge clock) begin
        if (reset)
            conflict_cnt <= '0;
        else if (conflict && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + 32'd1;
    end

    assign prf_write_en   = prf_q.write_en;
    assign prf_write_tag  = prf_q.write_tag;
    assign prf_write_data = prf_q.write_data;
    assign cdb_valid      = cdb_q.valid;
    assign cdb_tag        = cdb_q.tag;

endmodule
